// File: rtl/clock_set_ctrl.sv
// Button front end for Aclock: debounced set/inc/dec, field-by-field BCD HH:MM edit, load strobes.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on inc/dec.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES  = 50,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       sw_alarm,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic [1:0] edit_field
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

  // Button index: 0 = set, 1 = inc, 2 = dec
  logic [2:0]            raw, sync1_q, sync2_q, level_q, level_d, press;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

  state_t          state_q, state_d;
  logic            target_q, target_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic            ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic            in_edit, inc_ev, dec_ev, step_en, step_up, rpt_step, rpt_up;
  logic [5:0]      h_next;
  logic [7:0]      m_next;

  function automatic logic [5:0] hour_step(input logic [1:0] t, input logic [3:0] u,
                                           input logic up);
    logic [5:0] r;
    if (up) begin
      if (t == 2'd2 && u == 4'd3) r = 6'd0;
      else if (u == 4'd9)         r = {t + 2'd1, 4'd0};
      else                        r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
      else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] min_step(input logic [3:0] t, input logic [3:0] u,
                                          input logic up);
    logic [7:0] r;
    if (up) begin
      if (u == 4'd9) r = {(t == 4'd5) ? 4'd0 : t + 4'd1, 4'd0};
      else           r = {t, u + 4'd1};
    end else begin
      if (u == 4'd0) r = {(t == 4'd0) ? 4'd5 : t - 4'd1, 4'd9};
      else           r = {t, u - 4'd1};
    end
    return r;
  endfunction

  assign raw = {btn_dec, btn_inc, btn_set};

  // The press pulse fires in the cycle the debounced level is about to rise
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      level_d[b]  = level_q[b];
      db_cnt_d[b] = '0;
      press[b]    = 1'b0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[b] = sync2_q[b];
          press[b]   = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign in_edit = (state_q == EDIT_H) || (state_q == EDIT_M);
  assign inc_ev  = press[1] & ~press[2];
  assign dec_ev  = press[2] & ~press[1];

`ifdef AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);
  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;

  always_comb begin
    rpt_cnt_d   = '0;
    rpt_first_d = 1'b1;
    rpt_step    = 1'b0;
    if (in_edit && (level_q[1] ^ level_q[2]) && !(|press)) begin
      rpt_first_d = rpt_first_q;
      if (rpt_cnt_q + 1'b1 == (rpt_first_q ? RP_W'(REPEAT_DELAY) : RP_W'(REPEAT_RATE))) begin
        rpt_step    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end
  assign rpt_up = level_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_step = 1'b0;
  assign rpt_up   = 1'b0;
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_cfg_unused
  end
`endif

  assign step_en = in_edit && !press[0] && (inc_ev || dec_ev || rpt_step);
  assign step_up = inc_ev || (rpt_step && rpt_up);
  assign h_next  = hour_step(h1_q, h0_q, step_up);
  assign m_next  = min_step(m1_q, m0_q, step_up);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    to_d       = to_q;
    {h1_d, h0_d} = {h1_q, h0_q};
    {m1_d, m0_d} = {m1_q, m0_q};
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    case (state_q)
      IDLE: if (press[0]) begin
        state_d  = EDIT_H;
        target_d = sw_alarm;
        to_d     = '0;
      end
      EDIT_H, EDIT_M: begin
        if (press[0]) begin
          state_d = (state_q == EDIT_H) ? EDIT_M : COMMIT;
          to_d    = '0;
        end else if ((|press[2:1]) || rpt_step) begin
          to_d = '0;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
        if (step_en && state_q == EDIT_H) {h1_d, h0_d} = h_next;
        if (step_en && state_q == EDIT_M) {m1_d, m0_d} = m_next;
      end
      COMMIT: begin
        state_d    = IDLE;
        ld_time_d  = ~target_q;
        ld_alarm_d = target_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      target_q   <= 1'b0;
      to_q       <= '0;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      target_q   <= target_d;
      to_q       <= to_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  assign H_in1      = h1_q;
  assign H_in0      = h0_q;
  assign M_in1      = m1_q;
  assign M_in0      = m0_q;
  assign LD_time    = ld_time_q;
  assign LD_alarm   = ld_alarm_q;
  assign editing    = in_edit;
  assign edit_field = (state_q == EDIT_H) ? 2'b01 : (state_q == EDIT_M) ? 2'b10 : 2'b00;

endmodule
